// File: rtl/tx_rrc_interp2.sv
// tx_rrc_interp2: 16-tap polyphase RRC transmit filter with 2x interpolation.
// Two 8-tap phases share one multiplier; the coefficient bank is loaded serially.
module tx_rrc_interp2 #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned SHIFT = 15
) (
  input  logic          clk_61p44MHz,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] x_in,
  input  logic          coeff_we,
  input  logic [CW-1:0] coeff,
  output logic          out_valid,
  output logic [DW-1:0] y_out,
  output logic          overrun,
  output logic          cfg_err
);

  localparam int unsigned NTAP = 16;
  localparam int unsigned NDLY = 8;
  localparam int unsigned PW   = DW + CW;
  localparam int unsigned AW   = PW + 4;
  localparam logic [AW-1:0]        RND  = AW'(1) << (SHIFT - 1);
  localparam logic signed [AW-1:0] YMAX = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] YMIN = ~YMAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC0 = 2'd1,
    S_MAC1 = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [DW-1:0]        x_q [NDLY];
  logic [DW-1:0]        x_d [NDLY];
  logic [CW-1:0]        h_q [NTAP];
  logic [CW-1:0]        h_d [NTAP];
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        y_out_q, y_out_d;
  logic                 overrun_q, overrun_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 last_tap_c;
  logic                 in_acc_c;
  logic                 cf_acc_c;
  logic [3:0]           h_idx_c;
  logic signed [PW-1:0] prod_c;
  logic signed [AW-1:0] sum_c;
  logic signed [AW-1:0] rnd_c;
  logic [DW-1:0]        y_sat_c;

  assign out_valid = out_valid_q;
  assign y_out     = y_out_q;
  assign overrun   = overrun_q;
  assign cfg_err   = cfg_err_q;

  // Shared MAC datapath: tap select, multiply, accumulate, round and saturate.
  always_comb begin
    last_tap_c = (k_q == 3'd7);
    in_acc_c   = in_valid && ((state_q == S_IDLE) || ((state_q == S_MAC1) && last_tap_c));
    cf_acc_c   = coeff_we && (state_q == S_IDLE);
    h_idx_c    = {k_q, (state_q == S_MAC1)};
    prod_c     = PW'($signed(h_q[h_idx_c])) * PW'($signed(x_q[k_q]));
    sum_c      = (k_q == 3'd0) ? AW'(prod_c) : (acc_q + AW'(prod_c));
    rnd_c      = (sum_c + $signed(RND)) >>> SHIFT;
    y_sat_c    = DW'(rnd_c);
    if (rnd_c > YMAX) begin
      y_sat_c = DW'(YMAX);
    end else if (rnd_c < YMIN) begin
      y_sat_c = DW'(YMIN);
    end
  end

  // Next state: FSM sequencing, delay line and bank shifts, output capture, sticky flags.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    x_d         = x_q;
    h_d         = h_q;
    out_valid_d = 1'b0;
    y_out_d     = y_out_q;
    overrun_d   = overrun_q;
    cfg_err_d   = cfg_err_q;

    if (in_valid && !in_acc_c) overrun_d = 1'b1;
    if (coeff_we && !cf_acc_c) cfg_err_d = 1'b1;

    if (in_acc_c) begin
      for (int i = NDLY - 1; i > 0; i--) x_d[i] = x_q[i-1];
      x_d[0] = x_in;
    end

    if (cf_acc_c) begin
      for (int i = NTAP - 1; i > 0; i--) h_d[i] = h_q[i-1];
      h_d[0] = coeff;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_MAC0;
          k_d     = 3'd0;
        end
      end
      S_MAC0, S_MAC1: begin
        acc_d = sum_c;
        k_d   = k_q + 3'd1;
        if (last_tap_c) begin
          out_valid_d = 1'b1;
          y_out_d     = y_sat_c;
          k_d         = 3'd0;
          if (state_q == S_MAC0) begin
            state_d = S_MAC1;
          end else if (in_valid) begin
            state_d = S_MAC0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk_61p44MHz or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= 3'd0;
      acc_q       <= '0;
      for (int i = 0; i < NDLY; i++) x_q[i] <= '0;
      for (int i = 0; i < NTAP; i++) h_q[i] <= '0;
      out_valid_q <= 1'b0;
      y_out_q     <= '0;
      overrun_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      h_q         <= h_d;
      out_valid_q <= out_valid_d;
      y_out_q     <= y_out_d;
      overrun_q   <= overrun_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_tx_rrc_interp2.sv
// Testbench for tx_rrc_interp2: table-driven impulse runs, directed corner cases,
// and random traffic checked against a convolution model of the filter.
module tb_tx_rrc_interp2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] x_in = '0;
  logic        coeff_we = 1'b0;
  logic [15:0] coeff = '0;
  logic        out_valid;
  logic [15:0] y_out;
  logic        overrun;
  logic        cfg_err;

  always #5 clk = ~clk;

  tx_rrc_interp2 dut (
    .clk_61p44MHz (clk),
    .reset        (rst),
    .in_valid     (in_valid),
    .x_in         (x_in),
    .coeff_we     (coeff_we),
    .coeff        (coeff),
    .out_valid    (out_valid),
    .y_out        (y_out),
    .overrun      (overrun),
    .cfg_err      (cfg_err)
  );

  typedef struct { int due; logic [15:0] val; } exp_t;
  typedef struct { logic [15:0] x; logic [15:0] y0; logic [15:0] y1; } vec_t;

  int          n_pass = 0;
  int          n_total = 0;
  int          edge_n = 0;
  longint      hist [8];
  longint      hb [16];
  bit          have_last;
  int          last_acc;
  bit          ovr_exp;
  bit          cfg_exp;
  logic [15:0] y_hold;
  exp_t        eq [$];
  logic [15:0] got [$];
  vec_t        tbl [9];
  logic [15:0] bank_buf [16];

  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
  endtask

  // Direct-form convolution of one phase over the current bank and input history.
  function automatic longint fir(input int ph);
    longint s = 0;
    longint r;
    for (int k = 0; k < 8; k++) s += hb[2*k+ph] * hist[k];
    r = (s + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) hist[i] = 0;
    for (int i = 0; i < 16; i++) hb[i] = 0;
    have_last = 1'b0;
    last_acc  = 0;
    ovr_exp   = 1'b0;
    cfg_exp   = 1'b0;
    y_hold    = '0;
    eq.delete();
  endfunction

  // Model of one clock edge: an input is taken 16+ edges after the previous one,
  // a coefficient write only once the filter is idle (17+ edges).
  task automatic model_edge(input logic iv, input logic [15:0] xv, input logic cw, input logic [15:0] cv);
    bit acc_in, acc_cf;
    if (!rst) begin
      acc_cf = cw && (!have_last || (edge_n - last_acc >= 17));
      acc_in = iv && (!have_last || (edge_n - last_acc >= 16));
      if (cw && !acc_cf) cfg_exp = 1'b1;
      if (iv && !acc_in) ovr_exp = 1'b1;
      if (acc_cf) begin
        for (int i = 15; i > 0; i--) hb[i] = hb[i-1];
        hb[0] = sx(cv);
      end
      if (acc_in) begin
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sx(xv);
        eq.push_back('{edge_n + 8, 16'(fir(0))});
        eq.push_back('{edge_n + 16, 16'(fir(1))});
        have_last = 1'b1;
        last_acc  = edge_n;
      end
    end
  endtask

  task automatic check_outputs();
    logic        ev;
    logic [15:0] ey;
    ev = 1'b0;
    ey = y_hold;
    if (eq.size() > 0 && eq[0].due == edge_n) begin
      ev     = 1'b1;
      ey     = eq[0].val;
      y_hold = ey;
      void'(eq.pop_front());
    end
    chk("outputs{valid,y,ovr,cfg}", longint'({out_valid, y_out, overrun, cfg_err}),
        longint'({ev, ey, ovr_exp, cfg_exp}));
    if (out_valid) got.push_back(y_out);
  endtask

  // One clock: drive at negedge, model the posedge, check at the next negedge.
  task automatic cyc(input logic iv, input logic [15:0] xv, input logic cw, input logic [15:0] cv);
    in_valid = iv;
    x_in     = xv;
    coeff_we = cw;
    coeff    = cv;
    @(posedge clk);
    edge_n++;
    model_edge(iv, xv, cw, cv);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'd0, 1'b0, 16'd0);
  endtask

  task automatic send(input logic [15:0] xv, input int gap);
    cyc(1'b1, xv, 1'b0, 16'd0);
    idle(gap - 1);
  endtask

  task automatic load_bank();
    idle(20);
    for (int i = 15; i >= 0; i--) cyc(1'b0, 16'd0, 1'b1, bank_buf[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("reset outputs", longint'({out_valid, y_out, overrun, cfg_err}), 0);
    idle(3);
    rst = 1'b0;
  endtask

  task automatic impulse_bank();
    for (int i = 0; i < 16; i++) bank_buf[i] = 16'((i + 1) * 1024);
    load_bank();
  endtask

  // Flush the delay line, then play the table back-to-back and compare the output stream.
  task automatic run_table(input bit poke);
    repeat (8) send(16'd0, 16);
    idle(24);
    got.delete();
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, tbl[i].x, 1'b0, 16'd0);
      for (int j = 1; j < 16; j++) cyc(1'b0, 16'd0, poke && (i == 0) && (j == 3), 16'h7fff);
    end
    idle(24);
    chk("table count", got.size(), 18);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("table y0[%0d]", i), sx(got[2*i]), sx(tbl[i].y0));
      chk($sformatf("table y1[%0d]", i), sx(got[2*i+1]), sx(tbl[i].y1));
    end
  endtask

  initial begin
    int gap;
    tbl[0] = '{16'h7fff, 16'd1024, 16'd2048};
    for (int i = 1; i < 8; i++) tbl[i] = '{16'd0, 16'((2*i + 1) * 1024), 16'((2*i + 2) * 1024)};
    tbl[8] = '{16'd0, 16'd0, 16'd0};

    @(negedge clk);
    do_reset();

    // Impulse response and latency
    impulse_bank();
    run_table(1'b0);

    // Saturation, both rails
    for (int i = 0; i < 16; i++) bank_buf[i] = 16'h7fff;
    load_bank();
    got.delete();
    repeat (8) send(16'h7fff, 16);
    idle(20);
    chk("sat pos count", got.size(), 16);
    chk("sat pos", sx(got[15]), 32767);
    got.delete();
    repeat (8) send(16'h8000, 16);
    idle(20);
    chk("sat neg count", got.size(), 16);
    chk("sat neg", sx(got[15]), -32768);

    // Overrun: second sample arrives 10 cycles after the first and is dropped
    impulse_bank();
    send(16'd1000, 10);
    send(16'd12345, 6);
    send(16'd2000, 16);
    idle(20);
    chk("overrun flag", overrun, 1);

    // Coefficient write during MAC0 is ignored; impulse run must be unchanged
    run_table(1'b1);
    chk("cfg_err flag", cfg_err, 1);

    // Reset in the middle of MAC1, then a clean run
    send(16'd5000, 12);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midmac reset outputs", longint'({out_valid, y_out, overrun, cfg_err}), 0);
    idle(2);
    rst = 1'b0;
    idle(40);
    impulse_bank();
    run_table(1'b0);

    // Random traffic with random bank, mixed spacing and stray coefficient writes
    for (int i = 0; i < 16; i++) bank_buf[i] = 16'($urandom_range(8191, 0)) - 16'd4096;
    load_bank();
    gap = 0;
    for (int c = 0; c < 1500; c++) begin
      logic iv;
      logic cw;
      iv = (gap == 0);
      if (iv) gap = $urandom_range(23, 9);
      else gap--;
      cw = ($urandom_range(29, 0) == 0);
      cyc(iv, 16'($urandom), cw, 16'($urandom_range(8191, 0)) - 16'd4096);
    end
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
